// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller and its byte FIFO.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } rx_state_e;

    localparam int          DEF_DEPTH   = 4;
    localparam int          DEF_ARM_CYC = 4;
    localparam logic [7:0]  FERR_MAX    = 8'd255;

    function automatic logic [7:0] ferr_sat_inc(input logic [7:0] v);
        return (v == FERR_MAX) ? FERR_MAX : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO: a push at edge N is visible on rd_data_o right after edge N.
// Pop only when non-empty; a push while full without a same-cycle pop is dropped and flagged.
module uart_rx_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [7:0]        push_dat_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [7:0]        rd_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              drop_o
);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
    assign do_pop    = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the byte.
    assign do_push   = push_i && (!full_o || do_pop);
    assign drop_o    = push_i && full_o && !do_pop && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arms the receive FSM, queues bytes, records framing errors/overruns.
// Bytes reach rd_data the cycle after load_buffer; rd_valid/rd_ready handoff, overflow drops and sets overrun.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ARM_CYC = DEF_ARM_CYC
) (
    input  logic              CLOCK,
    input  logic              reset,
    input  logic              rx_en,
    input  logic              flush,
    input  logic              load_buffer,
    input  logic              SFE,
    input  logic [7:0]        rx_byte,
    output logic              rx_fsm_rst,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              frame_err,
    output logic [7:0]        ferr_cnt,
    input  logic              err_clr
);

    localparam int                ARM_W    = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_CYC - 1);

    rx_state_e         state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic              rx_fsm_rst_q, rx_fsm_rst_d;
    logic              run_acc;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        ferr_cnt_q, ferr_cnt_d;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              sfe_acc;

    always_ff @(posedge CLOCK) begin
        if (!reset) begin
            state_q   <= ST_OFF;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    always_comb begin
        state_d   = ST_OFF;
        arm_cnt_d = '0;
        case (state_q)
            ST_OFF: begin
                if (rx_en) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!rx_en) begin
                    state_d = ST_OFF;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d   = ST_ARM;
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_RUN: begin
                state_d = rx_en ? ST_RUN : ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Registering the next-state view keeps rx_fsm_rst glitch-free towards the receive FSM.
    always_comb begin
        rx_fsm_rst_d = (state_d != ST_RUN);
        run_acc      = (state_q == ST_RUN);
    end

    assign fifo_push = run_acc && load_buffer;
    assign sfe_acc   = run_acc && SFE;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i      (CLOCK),
        .rst_n_i    (reset),
        .push_i     (fifo_push),
        .push_dat_i (rx_byte),
        .pop_i      (rd_ready),
        .flush_i    (flush),
        .rd_data_o  (rd_data),
        .count_o    (count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (fifo_drop)
    );

    drop_implies_full: assert property (@(posedge CLOCK) disable iff (!reset) fifo_drop |-> fifo_full);

    // A fresh event in the err_clr cycle wins over the clear.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        ferr_cnt_d  = ferr_cnt_q;
        if (sfe_acc) begin
            frame_err_d = 1'b1;
            ferr_cnt_d  = err_clr ? 8'd1 : ferr_sat_inc(ferr_cnt_q);
        end else if (err_clr) begin
            frame_err_d = 1'b0;
            ferr_cnt_d  = 8'd0;
        end
        if (fifo_drop) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!reset) begin
            rx_fsm_rst_q <= 1'b1;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            ferr_cnt_q   <= 8'd0;
        end else begin
            rx_fsm_rst_q <= rx_fsm_rst_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            ferr_cnt_q   <= ferr_cnt_d;
        end
    end

    assign rx_fsm_rst = rx_fsm_rst_q;
    assign rd_valid   = !fifo_empty;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign ferr_cnt   = ferr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_uart_rx_ctrl;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;
    localparam int ARM_CYC = 4;

    logic              CLOCK = 1'b0;
    logic              reset = 1'b0;
    logic              rx_en = 1'b0;
    logic              flush = 1'b0;
    logic              load_buffer = 1'b0;
    logic              SFE = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              rd_ready = 1'b0;
    logic              err_clr = 1'b0;
    logic              rx_fsm_rst;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              frame_err;
    logic [7:0]        ferr_cnt;

    uart_rx_ctrl #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ARM_CYC (ARM_CYC)
    ) dut (
        .CLOCK       (CLOCK),
        .reset       (reset),
        .rx_en       (rx_en),
        .flush       (flush),
        .load_buffer (load_buffer),
        .SFE         (SFE),
        .rx_byte     (rx_byte),
        .rx_fsm_rst  (rx_fsm_rst),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .count       (count),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .ferr_cnt    (ferr_cnt),
        .err_clr     (err_clr)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=disabled, 1=arming (cycles of reset left), 2=receiving.
    int         m_mode = 0;
    int         m_left = 0;
    logic [7:0] mq[$];
    bit         m_ovr  = 1'b0;
    bit         m_ferr = 1'b0;
    int         m_fcnt = 0;

    always @(posedge CLOCK) begin
        bit run;
        bit pop;
        int sz;
        if (!reset) begin
            m_mode = 0;
            m_left = 0;
            mq.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            m_fcnt = 0;
        end else begin
            run = (m_mode == 2);
            sz  = mq.size();
            pop = rd_ready && (sz > 0);
            if (run && SFE) begin
                m_ferr = 1'b1;
                m_fcnt = err_clr ? 1 : ((m_fcnt < 255) ? m_fcnt + 1 : 255);
            end else if (err_clr) begin
                m_ferr = 1'b0;
                m_fcnt = 0;
            end
            if (err_clr) m_ovr = 1'b0;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (run && load_buffer) begin
                    if (sz < DEPTH || pop) mq.push_back(rx_byte);
                    else m_ovr = 1'b1;
                end
            end
            case (m_mode)
                0: if (rx_en) begin m_mode = 1; m_left = ARM_CYC; end
                1: begin
                    if (!rx_en) m_mode = 0;
                    else begin
                        m_left--;
                        if (m_left == 0) m_mode = 2;
                    end
                end
                default: if (!rx_en) m_mode = 0;
            endcase
        end
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("m_rx_fsm_rst", rx_fsm_rst, (m_mode != 2));
            chk("m_rd_valid", rd_valid, (mq.size() > 0));
            chk("m_count", count, mq.size());
            if (mq.size() > 0) chk("m_rd_data", rd_data, mq[0]);
            chk("m_overrun", overrun, m_ovr);
            chk("m_frame_err", frame_err, m_ferr);
            chk("m_ferr_cnt", ferr_cnt, m_fcnt);
        end
    end

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic push(input logic [7:0] b);
        load_buffer = 1'b1;
        rx_byte     = b;
        tick();
        load_buffer = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_fsm_rst", rx_fsm_rst, 1);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_ferr_cnt", ferr_cnt, 0);

        // Arming: four cycles of receiver reset, inputs ignored meanwhile.
        reset = 1'b1;
        rx_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin load_buffer = 1'b1; rx_byte = 8'h99; end
            if (i == 2) SFE = 1'b1;
            tick();
            load_buffer = 1'b0;
            SFE = 1'b0;
            chk("arm_rst_hi", rx_fsm_rst, 1);
        end
        tick();
        chk("run_rst_lo", rx_fsm_rst, 0);
        chk("arm_no_push", count, 0);
        chk("arm_no_ferr", frame_err, 0);

        // Basic queue and drain.
        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("q3_count", count, 3);
        chk("q3_head", rd_data, 8'h41);
        chk("q3_valid", rd_valid, 1);
        rd_ready = 1'b1;
        tick();
        chk("rd_42", rd_data, 8'h42);
        tick();
        chk("rd_43", rd_data, 8'h43);
        tick();
        chk("drained_valid", rd_valid, 0);
        tick();
        chk("no_underflow", count, 0);
        rd_ready = 1'b0;

        // Full, overflow drop, then push+pop at full.
        push(8'h10);
        push(8'h11);
        push(8'h12);
        push(8'h13);
        chk("full_count", count, 4);
        chk("full_no_ovr", overrun, 0);
        push(8'h14);
        chk("ovr_set", overrun, 1);
        chk("ovr_count", count, 4);
        chk("ovr_head", rd_data, 8'h10);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        load_buffer = 1'b1;
        rx_byte     = 8'h20;
        rd_ready    = 1'b1;
        tick();
        load_buffer = 1'b0;
        chk("pp_no_ovr", overrun, 0);
        chk("pp_count", count, 4);
        chk("pp_head", rd_data, 8'h11);
        tick();
        chk("pp_rd12", rd_data, 8'h12);
        tick();
        chk("pp_rd13", rd_data, 8'h13);
        tick();
        chk("pp_rd20", rd_data, 8'h20);
        tick();
        chk("pp_empty", rd_valid, 0);
        rd_ready = 1'b0;

        // Framing errors.
        for (int i = 0; i < 3; i++) begin
            SFE = 1'b1;
            tick();
            SFE = 1'b0;
        end
        chk("fe_flag", frame_err, 1);
        chk("fe_cnt3", ferr_cnt, 3);
        SFE = 1'b1;
        err_clr = 1'b1;
        tick();
        SFE = 1'b0;
        err_clr = 1'b0;
        chk("fe_clr_win_flag", frame_err, 1);
        chk("fe_clr_win_cnt", ferr_cnt, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("fe_clr_flag", frame_err, 0);
        chk("fe_clr_cnt", ferr_cnt, 0);
        chk("fe_clr_ovr", overrun, 0);
        SFE = 1'b1;
        repeat (260) tick();
        SFE = 1'b0;
        chk("fe_sat", ferr_cnt, 255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("fe_sat_clr", ferr_cnt, 0);

        // Disable with bytes queued; same-cycle byte still accepted.
        push(8'h55);
        push(8'h66);
        rx_en       = 1'b0;
        load_buffer = 1'b1;
        rx_byte     = 8'h77;
        tick();
        load_buffer = 1'b0;
        chk("dis_rst", rx_fsm_rst, 1);
        chk("dis_last_byte", count, 3);
        push(8'h88);
        chk("dis_ignored", count, 3);
        chk("dis_head", rd_data, 8'h55);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("dis_read", rd_data, 8'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", rd_valid, 0);

        // Reset in the middle of arming.
        rx_en = 1'b1;
        repeat (5) tick();
        chk("rerun", rx_fsm_rst, 0);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        push(8'h05);
        chk("pre_rst_ovr", overrun, 1);
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        chk("pre_rst_count", count, 2);
        rx_en = 1'b0;
        tick();
        rx_en = 1'b1;
        tick();
        tick();
        chk("pre_rst_arm", rx_fsm_rst, 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_fsm", rx_fsm_rst, 1);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_data", rd_data, 8'h00);
        reset = 1'b1;
        rx_en = 1'b0;
        tick();
        chk("post_rst_off", rx_fsm_rst, 1);
        rx_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rearm_hi", rx_fsm_rst, 1);
        end
        tick();
        chk("rearm_lo", rx_fsm_rst, 0);

        // Flush beats a same-cycle push; byte and SFE together both land.
        push(8'hA5);
        load_buffer = 1'b1;
        rx_byte     = 8'h5A;
        flush       = 1'b1;
        rd_ready    = 1'b1;
        tick();
        load_buffer = 1'b0;
        flush       = 1'b0;
        rd_ready    = 1'b0;
        chk("flush_wins", count, 0);
        load_buffer = 1'b1;
        SFE         = 1'b1;
        rx_byte     = 8'hC3;
        tick();
        load_buffer = 1'b0;
        SFE         = 1'b0;
        chk("both_count", count, 1);
        chk("both_data", rd_data, 8'hC3);
        chk("both_ferr", ferr_cnt, 1);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller between the UART receive datapath (receive FSM, baud counter, shift register, byte buffer) and the CPU-side byte consumer.
- Sequences receiver enable/arming and holds the receive FSM in reset while disabled.
- Queues completed bytes in a small FIFO with a valid/ready handoff.
- Records framing errors and overruns for software.

Parameters:
DEPTH, 4, FIFO entries; must be a power of 2, at least 2
ADDR_W, 2, log2(DEPTH)
ARM_CYC, 4, cycles the receive FSM is held in reset after enable before bytes are accepted

Ports:
CLOCK  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
rx_en  in  1  software receiver enable (level)
flush  in  1  single-cycle pulse; empties the FIFO
load_buffer  in  1  one-cycle pulse from the receive FSM: good stop bit, byte valid
SFE  in  1  one-cycle pulse from the receive FSM: bad stop bit (framing error)
rx_byte  in  8  received byte; valid in the cycle load_buffer is high
rx_fsm_rst  out  1  active-high reset to the receive FSM and baud counter
rd_data  out  8  FIFO head byte (show-ahead)
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts rd_data when rd_valid and rd_ready are both high
count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
overrun  out  1  sticky: a byte was dropped because the FIFO was full
frame_err  out  1  sticky: SFE was seen
ferr_cnt  out  8  saturating framing-error count
err_clr  in  1  single-cycle pulse; clears overrun, frame_err and ferr_cnt

Behaviour:
- Reset (reset=0 at a clock edge):
  - state OFF, rx_fsm_rst=1, FIFO empty (count=0, rd_valid=0, rd_data=0).
  - overrun=0, frame_err=0, ferr_cnt=0, arm counter=0.
- State machine, 2-bit encoding: OFF=0, ARM=1, RUN=2. Unused encoding 3 goes to OFF.
  - OFF: rx_fsm_rst=1; load_buffer and SFE are ignored. rx_en=1 -> ARM with arm counter cleared.
  - ARM: rx_fsm_rst=1; arm counter increments each cycle; inputs are ignored.
    - rx_en=0 -> OFF.
    - Counter reaching ARM_CYC-1 -> RUN. rx_fsm_rst is therefore high for exactly ARM_CYC cycles after the OFF exit.
  - RUN: rx_fsm_rst=0; load_buffer and SFE are accepted.
    - rx_en=0 -> OFF on the next edge; any partial frame is abandoned.
    - Inputs in that same cycle are still accepted.
- rx_fsm_rst is a registered output derived from the next state: it goes high the cycle after rx_en falls in RUN.
- FIFO:
  - Push when state is RUN and load_buffer=1.
  - Pop when rd_valid and rd_ready are both high.
  - Pointers are ADDR_W bits and wrap modulo DEPTH. count is updated +1, -1 or 0.
  - Push latency: a byte pushed at edge N appears on rd_data/rd_valid immediately after edge N.
  - rd_data = mem[rd_ptr]. When empty, rd_data holds the last value and is don't-care.
  - Full with push and no pop: byte dropped, overrun set, count stays DEPTH.
  - Full with simultaneous push and pop: both occur, no overrun, count stays DEPTH.
  - Empty: rd_ready is ignored and count never underflows.
  - flush: pointers and count cleared on that edge, overriding any same-cycle push/pop. Sticky flags are unaffected.
  - FIFO contents persist through OFF/ARM and remain readable while the receiver is disabled.
- Errors:
  - SFE in RUN sets frame_err and increments ferr_cnt, saturating at 255.
  - load_buffer and SFE are never high together. If they are, both are processed independently.
  - err_clr clears all three error outputs. A same-cycle new event wins: the flag is set and ferr_cnt is loaded with 1.
- Reset mid-operation overrides everything, including in-progress arming and queued bytes.

Decomposition:
- Shared package holds:
  - state encodings OFF/ARM/RUN;
  - default DEPTH=4 and ARM_CYC=4;
  - the FERR_MAX=255 constant.
- One sub-module: uart_rx_fifo.
  - Synchronous show-ahead FIFO with push, pop, flush, count, full, empty and overflow-drop indication.
  - Same CLOCK and active-low synchronous reset.
- Arming FSM, error flags and counter stay in uart_rx_ctrl.

Test Plan:
1. Reset released, rx_en=1 at cycle 0 -> rx_fsm_rst stays 1 for 4 cycles, then 0. A load_buffer pulse during ARM is not queued (count=0).
2. RUN: push 0x41, 0x42, 0x43 with rd_ready=0 -> count=3, rd_data=0x41. Hold rd_ready=1 -> reads 0x41, 0x42, 0x43 on consecutive cycles, then rd_valid=0.
3. Fill 4 bytes (0x10..0x13), push 0x14 -> overrun=1, count=4, and reads return 0x10..0x13. Next, at full, push 0x20 with a simultaneous pop -> no new overrun, count=4, 0x20 is the last entry.
4. 3 SFE pulses -> frame_err=1, ferr_cnt=3. err_clr together with a 4th SFE -> frame_err=1, ferr_cnt=1. err_clr alone -> all error outputs 0.
5. 2 bytes queued, rx_en=0 -> rx_fsm_rst=1 next cycle, bytes still readable. load_buffer pulses are now ignored. flush -> count=0, rd_valid=0.
6. Reset asserted mid-ARM with 2 bytes queued and overrun=1 -> next cycle: state OFF, count=0, overrun=0, rx_fsm_rst=1.
